down_counter_timer: RTL
=======================

Name: down_counter_timer

Overview:
- Programmable down-counting timer; the decrementing counterpart to the team's free-running up-counter.
- Software or an upstream controller loads a start value and a prescale through a valid/ready handshake, then starts the timer.
- The block counts down to zero, emits a one-cycle `done` pulse, and either stops or auto-reloads.
- Used as the shared event/timeout source for test and control logic.

Parameters:
- WIDTH, 4, width of count value and reload register.
- PRESCALE_W, 4, width of prescale divider value.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_valid  input  1  load request.
- load_ready  output  1  block can accept a load.
- load_value  input  WIDTH  start/reload value.
- load_prescale  input  PRESCALE_W  ticks occur every load_prescale+1 cycles.
- start  input  1  begin/resume counting.
- stop  input  1  pause counting.
- auto_reload  input  1  on expiry reload and continue (sampled at expiry).
- count  output  WIDTH  current count value.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle expiry pulse.

Behaviour:
- Interface: one clock `clk`; reset is asynchronous, active-low, port `rst_n`.
- Reset values (immediate on rst_n low):
  - state IDLE; count 0; reload_reg 0; pre_reg 0; pre_cnt 0.
  - busy 0; done 0; load_ready 1.
  - Reset mid-run aborts with no done pulse.
- States:
  - IDLE: no valid value.
  - LOADED: value held, not counting.
  - RUN: counting.
- Outputs from state:
  - load_ready = (state != RUN), combinational from state.
  - busy = (state == RUN), registered state.
- Load handshake: transfer when load_valid && load_ready.
  - count <= load_value; reload_reg <= load_value; pre_reg <= load_prescale; state -> LOADED.
  - Legal from IDLE or LOADED; overwrites a paused count.
  - load_valid while RUN is held off (load_ready 0, no state change).
- Start:
  - start in LOADED with no same-cycle load transfer: state -> RUN, pre_cnt <= pre_reg.
  - start in IDLE or RUN is ignored.
  - If load and start occur in the same cycle, the load wins; start is ignored.
- Prescaler, in RUN each cycle:
  - If pre_cnt == 0: tick, pre_cnt <= pre_reg.
  - Else: pre_cnt <= pre_cnt - 1.
- Tick with count != 0: count <= count - 1.
- Tick with count == 0 (expiry): done = 1 for exactly the next cycle.
  - auto_reload = 1: count <= reload_reg, stay RUN, prescaler continues seamlessly.
  - auto_reload = 0: count stays 0, state -> IDLE.
- Latency:
  - With value N and prescale P, done is high in the cycle after edge (N+1)*(P+1), counted from the edge that accepts start.
  - N = 0 expires on the first tick.
- Stop:
  - stop in RUN: state -> LOADED, count held, pre_cnt discarded.
  - A later start resumes from the held count with a fresh prescale period.
  - start and stop in the same cycle: stop wins (RUN -> LOADED; LOADED stays LOADED).
  - stop on an expiry edge: done still pulses; the expiry result applies, then state -> LOADED if auto_reload = 1.
- Arithmetic: all unsigned; no wrap below 0 (expiry handles the zero case); no overflow is possible.

Optional Feature:
- Macro DOWN_COUNTER_TIMER_IRQ_EN.
- Defined: adds ports irq (output 1) and irq_clr (input 1).
  - irq is sticky: set on any expiry, cleared by irq_clr.
  - If set and clear occur in the same cycle, set wins.
  - irq reset value 0.
- Undefined: the ports and logic are absent; only the done pulse is available.

Test Plan:
- Reset mid-run (load 4'd9, P=0, running at count 5), drop rst_n -> same cycle count=0, busy=0, done=0, load_ready=1; no done after release.
- Load 4'd3, P=0, auto_reload=0, start -> count 3,2,1,0 on successive edges; done high for the one cycle after the 4th edge; then busy=0, state IDLE, count 0.
- Load 4'd1, P=2, auto_reload=1 -> done pulses every 6 cycles; count pattern 1,1,1,0,0,0 repeating; busy stays 1.
- Load 4'd8, P=0, start; assert stop when count=5 -> count holds 5, busy=0, load_ready=1; start again -> done 6 edges after restart.
- Corner cases:
  - start and stop together in LOADED -> remains LOADED.
  - load_valid with 4'd2 while RUN -> load_ready=0, count unaffected.
  - Load 4'd0, P=0, start -> done after first edge.
- IRQ_EN build: expiry -> irq=1 and stays set; irq_clr on a later cycle -> irq=0; irq_clr coinciding with expiry -> irq stays 1.

Source files
------------

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - programmable down-counting timer with prescaler, stop/resume and auto-reload
// Optional build macro: DOWN_COUNTER_TIMER_IRQ_EN adds a sticky irq output with an irq_clr input.
module down_counter_timer #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [WIDTH-1:0]      load_value,
  input  logic [PRESCALE_W-1:0] load_prescale,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  auto_reload,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done
`ifdef DOWN_COUNTER_TIMER_IRQ_EN
  ,
  output logic                  irq,
  input  logic                  irq_clr
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    RUN    = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

  state_t                state, state_nxt;
  logic [WIDTH-1:0]      reload_reg, reload_nxt;
  logic [WIDTH-1:0]      count_nxt;
  logic [PRESCALE_W-1:0] pre_reg, pre_reg_nxt;
  logic [PRESCALE_W-1:0] pre_cnt, pre_cnt_nxt;
  logic                  tick;
  logic                  expire;

  // Handshake readiness and busy flag decode straight from the registered state.
  assign load_ready = (state != RUN);
  assign busy       = (state == RUN);

  // State and datapath registers; done is the registered expiry strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      pre_reg    <= '0;
      pre_cnt    <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      reload_reg <= reload_nxt;
      pre_reg    <= pre_reg_nxt;
      pre_cnt    <= pre_cnt_nxt;
      done       <= expire;
    end
  end

  // Next-state logic: load beats start, stop beats start, expiry beats stop.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    reload_nxt  = reload_reg;
    pre_reg_nxt = pre_reg;
    pre_cnt_nxt = pre_cnt;
    tick        = 1'b0;
    expire      = 1'b0;
    case (state)
      IDLE, LOADED: begin
        if (load_valid) begin
          count_nxt   = load_value;
          reload_nxt  = load_value;
          pre_reg_nxt = load_prescale;
          state_nxt   = LOADED;
        end else if ((state == LOADED) && start && !stop) begin
          pre_cnt_nxt = pre_reg;
          state_nxt   = RUN;
        end
      end
      RUN: begin
        tick        = (pre_cnt == '0);
        pre_cnt_nxt = tick ? pre_reg : (pre_cnt - PRE_ONE);
        if (tick && (count == '0)) begin
          // Expiry always completes, even when stop arrives on the same edge.
          expire = 1'b1;
          if (auto_reload) begin
            count_nxt = reload_reg;
            state_nxt = stop ? LOADED : RUN;
          end else begin
            state_nxt = IDLE;
          end
        end else if (stop) begin
          // Pausing freezes the count; the partial prescale period is dropped.
          state_nxt = LOADED;
        end else if (tick) begin
          count_nxt = count - CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef DOWN_COUNTER_TIMER_IRQ_EN
  // Sticky interrupt: set by any expiry, a coincident clear loses to the set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else if (expire) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule
